secded16_encoder_pipe: RTL
==========================

Name: secded16_encoder_pipe

Overview:
- Pipelined SEC/DED encoder for 16-bit data words; the companion of the team's c1908-class SEC/DED checker/corrector.
- Produces 22-bit extended-Hamming codewords: 16 data bits, 5 positional check bits and 1 overall-parity bit.
- Sits between a data source and the decoder under test. It supplies golden codewords for SAT-attack and locked-netlist evaluation benches, with valid/ready flow control on both sides.

Parameters:
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  encoder can accept a word
- in_data  input  16  data word
- inj_mask  input  22  error-injection mask (used only with SECDED_ERR_INJ_EN; otherwise ignored)
- out_valid  output  1  codeword valid
- out_ready  input  1  sink accepts codeword
- out_code  output  22  codeword; bit i = Hamming position i
- word_cnt  output  CNT_W  count of codewords delivered

Behaviour:
- Reset (rst=1 at a clk edge):
  - all valids cleared; out_code=0; word_cnt=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-transfer discards both pipeline stages without emitting them.
- Stage S1 (capture):
  - registers in_data and inj_mask on the in_valid && in_ready handshake.
  - s1_valid is set on that handshake.
- Stage S2 (encode):
  - registers the computed codeword (XOR with the S1 mask when the feature is enabled).
  - sets out_valid.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Throughput and latency:
  - Full throughput: one word per cycle when out_ready is held at 1.
  - Latency: a word accepted at edge N gives out_valid=1 after edge N+1.
  - A bubble in S1 with s2_adv=1 clears out_valid.
- Output holding: out_code and out_valid stay stable while out_valid && !out_ready.
- Data placement:
  - in_data[k] goes to positions 3,5,6,7,9,10,11,12,13,14,15,17,18,19,20,21, in order for k=0..15.
- Check bits:
  - code[2^j] = XOR of all data positions p (p in 3..21) with bit j of p set, for j=0..4 (positions 1,2,4,8,16).
- Overall parity: code[0] = XOR of code[21:1], giving even overall parity.
- Word counter:
  - word_cnt increments by 1 on each out_valid && out_ready.
  - wraps from 2^CNT_W-1 to 0.
  - does not count injected-vs-clean separately.
- Simultaneous accept and deliver in one cycle is legal: both stages shift, and the counter increments.

Optional Feature:
- Macro: SECDED_ERR_INJ_EN
- Enabled:
  - out_code = encode(data) XOR the inj_mask captured with that word.
  - 1-bit masks model correctable errors; 2-bit masks model detectable errors for the downstream decoder.
- Disabled:
  - inj_mask is unused and not registered.
  - out_code = clean encode(data).

Test Plan:
- Reset, then in_data=0x0000 with out_ready=1: out_valid rises 2 cycles after accept, out_code=0x000000, word_cnt=1.
- in_data=0xFFFF -> out_code=0x3FFFFC; in_data=0x0001 -> out_code=0x00000F.
- Back-to-back stream 0x0001, 0xFFFF, 0x0000 with out_ready=1:
  - codes 0x00000F, 0x3FFFFC, 0x000000 on consecutive cycles.
  - in_ready constantly 1; word_cnt=3.
- Backpressure with out_ready=0 for 5 cycles during the stream:
  - out_code held stable.
  - in_ready drops once S1 and S2 are both full.
  - no loss or duplication after release.
- Reset asserted while both stages are valid: next cycle out_valid=0, word_cnt=0, and no stale codeword appears later.
- With SECDED_ERR_INJ_EN: in_data=0x0001, inj_mask=0x000010 -> out_code=0x00001F. Without the macro, the same stimulus gives 0x00000F.
- CNT_W=4: deliver 17 words -> word_cnt wraps and reads 1.

Source files
------------

// File: rtl/secded16_encoder_pipe.sv
// Two-stage SEC/DED (22,16) extended-Hamming encoder with valid/ready on both sides.
// Optional error injection: define SECDED_ERR_INJ_EN to XOR a captured inj_mask into out_code.
module secded16_encoder_pipe #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic [21:0]      inj_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [21:0]      out_code,
   output logic [CNT_W-1:0] word_cnt
);

   // Data bits fill non-power-of-two positions 3..21; check bit 2^j covers positions with bit j set.
   function automatic logic [21:0] encode(input logic [15:0] d);
      logic [21:0] c;
      int          k;
      logic        par;
      c = '0;
      k = 0;
      for (int p = 3; p < 22; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p] = d[k];
            k++;
         end
      end
      for (int j = 0; j < 5; j++) begin
         par = 1'b0;
         for (int p = 3; p < 22; p++) begin
            if (p[j]) par = par ^ c[p];
         end
         c[1 << j] = par;
      end
      c[0] = ^c[21:1];
      return c;
   endfunction

   logic             s1_valid_q, s1_valid_d;
   logic [15:0]      s1_data_q, s1_data_d;
   logic             out_valid_q, out_valid_d;
   logic [21:0]      out_code_q, out_code_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic             s1_adv, s2_adv;
   logic [21:0]      s1_code;

`ifdef SECDED_ERR_INJ_EN
   logic [21:0]      s1_mask_q, s1_mask_d;
`else
   logic             unused_inj_mask;
   assign unused_inj_mask = ^inj_mask;
`endif

   always_comb begin
      s2_adv      = !out_valid_q || out_ready;
      s1_adv      = !s1_valid_q || s2_adv;
      s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
      s1_data_d   = (s1_adv && in_valid) ? in_data : s1_data_q;
`ifdef SECDED_ERR_INJ_EN
      s1_mask_d   = (s1_adv && in_valid) ? inj_mask : s1_mask_q;
      s1_code     = encode(s1_data_q) ^ s1_mask_q;
`else
      s1_code     = encode(s1_data_q);
`endif
      out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
      // Code only loads on a real word so a bubble leaves the last code visible but invalid.
      out_code_d  = (s2_adv && s1_valid_q) ? s1_code : out_code_q;
      word_cnt_d  = word_cnt_q + CNT_W'(out_valid_q && out_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
`ifdef SECDED_ERR_INJ_EN
         s1_mask_q   <= '0;
`endif
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         word_cnt_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
`ifdef SECDED_ERR_INJ_EN
         s1_mask_q   <= s1_mask_d;
`endif
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign word_cnt  = word_cnt_q;

endmodule
